// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave):
// instruction fields and status flags in, datapath steering and memory strobes out.
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_we;
   logic       iord;
   logic       mem_re;
   logic       mem_we;
   logic       ir_we;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_zero;
   logic [1:0] pc_src;
   logic [3:0] alu_op;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, ext_zero, pc_src, alu_op, illegal, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, ext_zero, pc_src, alu_op, illegal, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS-subset datapath. Moore controls are registered
// from the next state; only mem_ready/zero-qualified enables and the illegal pulse are combinational.
module multicycle_ctrl (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADDR  = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXEC_R   = 4'd7,
      RWB      = 4'd8,
      EXEC_I   = 4'd9,
      IWB      = 4'd10,
      BRANCH   = 4'd11,
      JUMP     = 4'd12
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // The in_* flags let the combinational enables know the current state without re-decoding it.
   typedef struct packed {
      logic       iord;
      logic       mem_re;
      logic       mem_we;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_src;
      logic [3:0] alu_op;
      logic       in_fetch;
      logic       in_decode;
      logic       in_branch;
      logic       in_jump;
   } ctrl_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl_q;
   logic   take_branch;

   function automatic logic [4:0] r_decode(input logic [5:0] f);
      case (f)
         6'h20, 6'h21: return {1'b1, ALU_ADD};
         6'h22, 6'h23: return {1'b1, ALU_SUB};
         6'h24:        return {1'b1, ALU_AND};
         6'h25:        return {1'b1, ALU_OR};
         6'h26:        return {1'b1, ALU_XOR};
         6'h27:        return {1'b1, ALU_NOR};
         6'h2A:        return {1'b1, ALU_SLT};
         6'h2B:        return {1'b1, ALU_SLTU};
         default:      return {1'b0, ALU_ADD};
      endcase
   endfunction

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] f);
      logic [4:0] r;
      r = r_decode(f);
      case (op)
         OP_RTYPE: return r[4];
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                         input logic [5:0] f, input logic ready);
      case (s)
         IDLE:     return FETCH;
         FETCH:    return ready ? DECODE : FETCH;
         DECODE: begin
            if (!is_legal(op, f)) return FETCH;
            case (op)
               OP_RTYPE:      return EXEC_R;
               OP_LW, OP_SW:  return MEMADDR;
               OP_BEQ, OP_BNE: return BRANCH;
               OP_J:          return JUMP;
               default:       return EXEC_I;
            endcase
         end
         MEMADDR:  return (op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  return ready ? MEMWB : MEMREAD;
         MEMWRITE: return ready ? FETCH : MEMWRITE;
         EXEC_R:   return RWB;
         EXEC_I:   return IWB;
         default:  return FETCH;
      endcase
   endfunction

   function automatic ctrl_t outputs_for(input state_t s, input logic [5:0] op, input logic [5:0] f);
      ctrl_t      c;
      logic [4:0] r;
      c = '0;
      r = r_decode(f);
      case (s)
         FETCH:    begin c.mem_re = 1'b1; c.alu_src_b = 2'd1; c.in_fetch = 1'b1; end
         DECODE:   begin c.alu_src_b = 2'd3; c.in_decode = 1'b1; end
         MEMADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
         MEMREAD:  begin c.mem_re = 1'b1; c.iord = 1'b1; end
         MEMWB:    begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
         MEMWRITE: begin c.mem_we = 1'b1; c.iord = 1'b1; end
         EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = r[3:0]; end
         RWB:      begin c.reg_we = 1'b1; c.reg_dst = 1'b1; end
         EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            case (op)
               OP_SLTI: c.alu_op = ALU_SLT;
               OP_ANDI: begin c.alu_op = ALU_AND; c.ext_zero = 1'b1; end
               OP_ORI:  begin c.alu_op = ALU_OR;  c.ext_zero = 1'b1; end
               default: c.alu_op = ALU_ADD;
            endcase
         end
         IWB:      c.reg_we = 1'b1;
         BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'd1; c.in_branch = 1'b1; end
         JUMP:     begin c.pc_src = 2'd2; c.in_jump = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   assign state_d = next_state(state_q, bus.opcode, bus.funct, bus.mem_ready);

   // Decoding the next state here means every Moore output is ready from a flop at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= outputs_for(state_d, bus.opcode, bus.funct);
      end
   end

   assign take_branch = (bus.opcode == OP_BEQ) ? bus.zero : ((bus.opcode == OP_BNE) & ~bus.zero);

   assign bus.pc_we      = (ctrl_q.in_fetch & bus.mem_ready) | ctrl_q.in_jump |
                           (ctrl_q.in_branch & take_branch);
   assign bus.ir_we      = ctrl_q.in_fetch & bus.mem_ready;
   assign bus.illegal    = ctrl_q.in_decode & ~is_legal(bus.opcode, bus.funct);
   assign bus.iord       = ctrl_q.iord;
   assign bus.mem_re     = ctrl_q.mem_re;
   assign bus.mem_we     = ctrl_q.mem_we;
   assign bus.reg_we     = ctrl_q.reg_we;
   assign bus.reg_dst    = ctrl_q.reg_dst;
   assign bus.mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.alu_src_a  = ctrl_q.alu_src_a;
   assign bus.alu_src_b  = ctrl_q.alu_src_b;
   assign bus.ext_zero   = ctrl_q.ext_zero;
   assign bus.pc_src     = ctrl_q.pc_src;
   assign bus.alu_op     = ctrl_q.alu_op;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level reference model compared every cycle,
// plus directed instruction scenarios with hand-computed expectations.
module tb_multicycle_ctrl;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADDR = 3, S_MEMREAD = 4,
                  S_MEMWB = 5, S_MEMWRITE = 6, S_EXEC_R = 7, S_RWB = 8, S_EXEC_I = 9,
                  S_IWB = 10, S_BRANCH = 11, S_JUMP = 12;

   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0010, ALU_AND = 4'b0111,
                          ALU_OR = 4'b1000, ALU_XOR = 4'b1001, ALU_NOR = 4'b1010,
                          ALU_SLT = 4'b1011, ALU_SLTU = 4'b1100;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                          OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                          OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                          OP_LW = 6'b100011, OP_SW = 6'b101011;

   typedef enum {I_LW, I_SW, I_BEQ, I_BNE, I_J, I_R, I_ADD_IMM, I_SLTI, I_ANDI, I_ORI, I_BAD} iclass_t;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_src;
      logic [3:0] alu_op;
      logic       illegal;
   } outs_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    checks = 0;
   int    errors = 0;
   int    exp_state = S_IDLE;
   bit    rec_en = 1'b0;
   outs_t trace[$];

   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic bit r_known(input logic [5:0] fn);
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
   endfunction

   function automatic logic [3:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'h22, 6'h23: return ALU_SUB;
         6'h24:        return ALU_AND;
         6'h25:        return ALU_OR;
         6'h26:        return ALU_XOR;
         6'h27:        return ALU_NOR;
         6'h2A:        return ALU_SLT;
         6'h2B:        return ALU_SLTU;
         default:      return ALU_ADD;
      endcase
   endfunction

   function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_LW:             return I_LW;
         OP_SW:             return I_SW;
         OP_BEQ:            return I_BEQ;
         OP_BNE:            return I_BNE;
         OP_J:              return I_J;
         OP_R:              return r_known(fn) ? I_R : I_BAD;
         OP_ADDI, OP_ADDIU: return I_ADD_IMM;
         OP_SLTI:           return I_SLTI;
         OP_ANDI:           return I_ANDI;
         OP_ORI:            return I_ORI;
         default:           return I_BAD;
      endcase
   endfunction

   function automatic int model_next(input int s, input logic [5:0] op, input logic [5:0] fn,
                                     input logic mr);
      iclass_t k;
      k = classify(op, fn);
      case (s)
         S_IDLE:     return S_FETCH;
         S_FETCH:    return mr ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (k)
               I_LW, I_SW:   return S_MEMADDR;
               I_BEQ, I_BNE: return S_BRANCH;
               I_J:          return S_JUMP;
               I_R:          return S_EXEC_R;
               I_BAD:        return S_FETCH;
               default:      return S_EXEC_I;
            endcase
         end
         S_MEMADDR:  return (k == I_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  return mr ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: return mr ? S_FETCH : S_MEMWRITE;
         S_EXEC_R:   return S_RWB;
         S_EXEC_I:   return S_IWB;
         default:    return S_FETCH;
      endcase
   endfunction

   function automatic outs_t model_outputs(input int s, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic mr);
      outs_t   o;
      iclass_t k;
      o = '0;
      k = classify(op, fn);
      o.state = s[3:0];
      case (s)
         S_FETCH:    begin o.mem_re = 1; o.alu_src_b = 2'd1; o.ir_we = mr; o.pc_we = mr; end
         S_DECODE:   begin o.alu_src_b = 2'd3; o.illegal = (k == I_BAD); end
         S_MEMADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
         S_MEMREAD:  begin o.mem_re = 1; o.iord = 1; end
         S_MEMWB:    begin o.reg_we = 1; o.mem_to_reg = 1; end
         S_MEMWRITE: begin o.mem_we = 1; o.iord = 1; end
         S_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = r_alu(fn); end
         S_RWB:      begin o.reg_we = 1; o.reg_dst = 1; end
         S_EXEC_I: begin
            o.alu_src_a = 1;
            o.alu_src_b = 2'd2;
            o.ext_zero  = (k == I_ANDI) || (k == I_ORI);
            o.alu_op    = (k == I_SLTI) ? ALU_SLT : (k == I_ANDI) ? ALU_AND :
                          (k == I_ORI) ? ALU_OR : ALU_ADD;
         end
         S_IWB:      o.reg_we = 1;
         S_BRANCH: begin
            o.alu_src_a = 1; o.alu_op = ALU_SUB; o.pc_src = 2'd1;
            o.pc_we = ((k == I_BEQ) && z) || ((k == I_BNE) && !z);
         end
         S_JUMP:     begin o.pc_src = 2'd2; o.pc_we = 1; end
         default:    o.state = s[3:0];
      endcase
      return o;
   endfunction

   function automatic outs_t dut_outs();
      outs_t o;
      o.state = bus.state;       o.pc_we = bus.pc_we;         o.iord = bus.iord;
      o.mem_re = bus.mem_re;     o.mem_we = bus.mem_we;       o.ir_we = bus.ir_we;
      o.reg_we = bus.reg_we;     o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
      o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.ext_zero = bus.ext_zero;
      o.pc_src = bus.pc_src;     o.alu_op = bus.alu_op;       o.illegal = bus.illegal;
      return o;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, actual, required);
      end
   endtask

   function automatic int count_reg_we();
      int n = 0;
      foreach (trace[i]) n += int'(trace[i].reg_we);
      return n;
   endfunction

   function automatic int count_mem_we();
      int n = 0;
      foreach (trace[i]) n += int'(trace[i].mem_we);
      return n;
   endfunction

   // The model follows the instruction flow and resets asynchronously alongside the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_state <= S_IDLE;
      else        exp_state <= model_next(exp_state, bus.opcode, bus.funct, bus.mem_ready);
   end

   always @(negedge clk) begin
      outs_t got;
      got = dut_outs();
      check_output("outputs", got, model_outputs(exp_state, bus.opcode, bus.funct, bus.zero, bus.mem_ready));
      if (rec_en) trace.push_back(got);
   end

   // Runs one instruction from FETCH back to FETCH; mem_ready toggles freely in states that ignore it.
   task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int fetch_wait, input int mem_wait);
      int fw, mw;
      bit left_fetch, done;
      fw = fetch_wait; mw = mem_wait; left_fetch = 0; done = 0;
      trace.delete();
      bus.opcode = op; bus.funct = fn; bus.zero = z;
      rec_en = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         if (exp_state == S_FETCH) begin
            bus.mem_ready = (fw == 0);
            if (fw > 0) fw--;
         end else if (exp_state == S_MEMREAD || exp_state == S_MEMWRITE) begin
            bus.mem_ready = (mw == 0);
            if (mw > 0) mw--;
         end else begin
            bus.mem_ready = c[0];
         end
         @(posedge clk); #1;
         if (exp_state != S_FETCH) left_fetch = 1;
         else if (left_fetch) done = 1;
      end
      rec_en = 1'b0;
      check_output("instr_completed", 32'(done), 1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lw_seq[5] = '{1, 2, 3, 4, 5};
      logic [5:0] br_op[4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
      logic       br_z[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic       br_pc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [5:0] sw_op[14] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R,
                                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ORI, 6'b111111, OP_LW};
      logic [5:0] sw_fn[14] = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

      rst_n = 1'b0;
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_output("reset_state", bus.state, S_IDLE);
      check_output("reset_outputs", dut_outs(), '0);
      #1 rst_n = 1'b1;
      #1 check_output("idle_after_release", bus.state, S_IDLE);
      @(posedge clk); #1;
      check_output("first_edge_fetch", bus.state, S_FETCH);

      apply_stimulus(OP_LW, 6'h00, 1'b0, 0, 0);
      check_output("lw_len", trace.size(), 5);
      for (int i = 0; i < 5 && i < trace.size(); i++)
         check_output($sformatf("lw_state%0d", i), trace[i].state, lw_seq[i]);
      check_output("lw_reg_we_count", count_reg_we(), 1);
      if (trace.size() >= 5) begin
         check_output("lw_memwb_reg_we", trace[4].reg_we, 1);
         check_output("lw_memwb_mem_to_reg", trace[4].mem_to_reg, 1);
      end
      check_output("lw_back_to_fetch", bus.state, S_FETCH);

      apply_stimulus(OP_SW, 6'h00, 1'b0, 0, 3);
      check_output("sw_mem_we_cycles", count_mem_we(), 4);
      check_output("sw_reg_we_count", count_reg_we(), 0);
      check_output("sw_back_to_fetch", bus.state, S_FETCH);

      for (int i = 0; i < 4; i++) begin
         apply_stimulus(br_op[i], 6'h00, br_z[i], 0, 0);
         if (trace.size() >= 3) begin
            check_output($sformatf("branch%0d_state", i), trace[2].state, S_BRANCH);
            check_output($sformatf("branch%0d_pc_we", i), trace[2].pc_we, br_pc[i]);
         end
      end

      apply_stimulus(OP_R, 6'h27, 1'b0, 0, 0);
      if (trace.size() >= 4) begin
         check_output("nor_state", trace[2].state, S_EXEC_R);
         check_output("nor_alu_op", trace[2].alu_op, 4'b1010);
         check_output("nor_rwb_reg_dst", trace[3].reg_dst, 1);
      end

      apply_stimulus(OP_R, 6'h3F, 1'b0, 0, 0);
      check_output("bad_funct_len", trace.size(), 2);
      if (trace.size() >= 2) begin
         check_output("bad_funct_fetch_illegal", trace[0].illegal, 0);
         check_output("bad_funct_decode_illegal", trace[1].illegal, 1);
      end
      check_output("bad_funct_reg_we", count_reg_we(), 0);
      check_output("bad_funct_back_to_fetch", bus.state, S_FETCH);

      apply_stimulus(OP_ANDI, 6'h15, 1'b0, 0, 0);
      if (trace.size() >= 4) begin
         check_output("andi_ext_zero", trace[2].ext_zero, 1);
         check_output("andi_alu_op", trace[2].alu_op, 4'b0111);
         check_output("andi_iwb_reg_we", trace[3].reg_we, 1);
         check_output("andi_iwb_reg_dst", trace[3].reg_dst, 0);
      end

      apply_stimulus(OP_J, 6'h00, 1'b0, 0, 0);
      if (trace.size() >= 3) begin
         check_output("jump_state", trace[2].state, S_JUMP);
         check_output("jump_pc_we", trace[2].pc_we, 1);
         check_output("jump_pc_src", trace[2].pc_src, 2);
      end

      apply_stimulus(OP_R, 6'h20, 1'b0, 2, 0);
      if (trace.size() >= 3) begin
         check_output("fetch_wait_ir_we", trace[0].ir_we, 0);
         check_output("fetch_done_ir_we", trace[2].ir_we, 1);
         check_output("fetch_done_pc_we", trace[2].pc_we, 1);
      end

      for (int i = 0; i < 14; i++) apply_stimulus(sw_op[i], sw_fn[i], 1'b0, 0, 2);

      // Pull reset between edges while a load is parked in MEMREAD.
      bus.opcode = OP_LW; bus.funct = 6'h00; bus.mem_ready = 1'b1;
      for (int c = 0; c < 10 && exp_state != S_MEMREAD; c++) begin
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      check_output("reached_memread", bus.state, S_MEMREAD);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_reset_state", bus.state, S_IDLE);
      check_output("async_reset_mem_re", bus.mem_re, 0);
      check_output("async_reset_outputs", dut_outs(), '0);
      @(negedge clk); #2 rst_n = 1'b1;
      #1 check_output("idle_after_mid_reset", bus.state, S_IDLE);
      @(posedge clk); #1;
      check_output("fetch_after_mid_reset", bus.state, S_FETCH);

      apply_stimulus(OP_ORI, 6'h00, 1'b0, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port opcode, input, 6: IR[31:26]; stable from DECODE until return to FETCH.
REQ-005 Port funct, input, 6: IR[5:0]; same stability as opcode.
REQ-006 Port zero, input, 1: ALU equality flag; sampled only in BRANCH.
REQ-007 Port mem_ready, input, 1: memory completion handshake.
REQ-008 Port pc_we, output, 1: PC write enable.
REQ-009 Port iord, output, 1: memory address select (0 PC, 1 ALUOut).
REQ-010 Port mem_re, output, 1: memory read request.
REQ-011 Port mem_we, output, 1: memory write request.
REQ-012 Port ir_we, output, 1: instruction register write enable.
REQ-013 Port reg_we, output, 1: register file write enable.
REQ-014 Port reg_dst, output, 1: destination select (0 rt, 1 rd).
REQ-015 Port mem_to_reg, output, 1: writeback source (0 ALUOut, 1 MDR).
REQ-016 Port alu_src_a, output, 1: operand A source (0 PC, 1 register A).
REQ-017 Port alu_src_b, output, 2: operand B source (0 register B, 1 constant 4, 2 extended immediate, 3 extended immediate shifted left by 2).
REQ-018 Port ext_zero, output, 1: immediate extension (1 zero-extend, 0 sign-extend).
REQ-019 Port pc_src, output, 2: next-PC source (0 ALU result, 1 ALUOut, 2 jump target).
REQ-020 Port alu_op, output, 4: ALU operation code (ADD 0000, SUB 0010, AND 0111, OR 1000, XOR 1001, NOR 1010, SLT 1011, SLTU 1100).
REQ-021 Port illegal, output, 1: one-cycle pulse for an undecodable instruction.
REQ-022 Port state, output, 4: current state code, for debug.

Function
REQ-023 State codes SHALL be: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXEC_R 7, RWB 8, EXEC_I 9, IWB 10, BRANCH 11, JUMP 12.
REQ-024 Outputs SHALL be Moore-decoded from state (pc_we in BRANCH excepted); any output not listed for a state SHALL be 0.
REQ-025 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-026 FETCH: mem_re=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0; ir_we=pc_we=mem_ready; hold in FETCH until mem_ready=1, then go to DECODE.
REQ-027 DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target to ALUOut).
REQ-028 DECODE next state by opcode: 000000→EXEC_R; 100011 (lw) or 101011 (sw)→MEMADDR; 000100 (beq) or 000101 (bne)→BRANCH; 000010 (j)→JUMP; 001000, 001001, 001010, 001100, 001101 (addi, addiu, slti, andi, ori)→EXEC_I; any other opcode→FETCH with illegal=1 for that cycle.
REQ-029 If opcode=000000 and funct is not listed in REQ-032, DECODE SHALL instead assert illegal=1 and go to FETCH, so the instruction executes as a nop.
REQ-030 MEMADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD, ext_zero=0; lw→MEMREAD, sw→MEMWRITE.
REQ-031 MEMREAD: mem_re=1, iord=1; hold until mem_ready=1, then go to MEMWB. MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; then FETCH. MEMWRITE: mem_we=1, iord=1; hold until mem_ready=1, then go to FETCH.
REQ-032 EXEC_R: alu_src_a=1, alu_src_b=0; alu_op from funct: 0x20/0x21→ADD, 0x22/0x23→SUB, 0x24→AND, 0x25→OR, 0x26→XOR, 0x27→NOR, 0x2A→SLT, 0x2B→SLTU; then RWB. RWB: reg_we=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-033 EXEC_I: alu_src_a=1, alu_src_b=2; addi/addiu→ADD, slti→SLT, andi→AND with ext_zero=1, ori→OR with ext_zero=1; then IWB. IWB: reg_we=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-034 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1; pc_we=(beq&zero)|(bne&~zero); then FETCH.
REQ-035 JUMP: pc_src=2, pc_we=1; then FETCH.
REQ-036 Unused state codes 13-15: all outputs 0; next state FETCH.
REQ-037 mem_ready SHALL be ignored in all states other than FETCH, MEMREAD and MEMWRITE.
REQ-038 mem_re and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-039 rst_n=0 SHALL force state to IDLE immediately, independent of clk, with all outputs 0, including when asserted mid-transaction.
REQ-040 After rst_n deasserts, the first clock edge SHALL move IDLE→FETCH.

Verification
REQ-041 lw with mem_ready tied to 1 → states 1,2,3,4,5,1; reg_we=1 only in MEMWB with mem_to_reg=1; 5 cycles per instruction.
REQ-042 sw with mem_ready held low for 3 cycles in MEMWRITE → mem_we=1 for 4 cycles, then FETCH; reg_we never asserted.
REQ-043 beq with zero=0, then beq with zero=1 → pc_we=0 and pc_we=1 respectively in BRANCH; bne gives the inverse result.
REQ-044 R-type with funct=0x27 → alu_op=1010 in EXEC_R; with funct=0x3F → illegal pulse in DECODE, next state FETCH, no reg_we.
REQ-045 rst_n pulled low mid-MEMREAD (asynchronously, between edges) → state=0 and mem_re=0 at once; after release, one IDLE cycle, then FETCH.
REQ-046 andi → ext_zero=1 and alu_op=0111 in EXEC_I, then IWB with reg_we=1 and reg_dst=0.
